// File: rtl/asic_bridge_pkg.sv
// Shared types and widths for the ASIC readout scheduler.
// Holds the sweep FSM state enum and datapath widths.
package asic_bridge_pkg;

   localparam int NUM_CH = 4;
   localparam int ADC_W  = 12;
   localparam int ACC_W  = 15;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      READ_REQ,
      READ_WAIT,
      STORE,
      COMPARE
   } state_t;

endpackage

// File: rtl/channel_argmax.sv
// Index of the largest of four ADC results.
// Ties resolve to the lowest channel index.
module channel_argmax
   import asic_bridge_pkg::*;
(
   input  logic [ADC_W-1:0] a0,
   input  logic [ADC_W-1:0] a1,
   input  logic [ADC_W-1:0] a2,
   input  logic [ADC_W-1:0] a3,
   output logic [1:0]       idx
);

   logic [ADC_W-1:0] best;

   // Strict greater-than keeps the earlier index on ties
   always_comb begin
      idx  = 2'd0;
      best = a0;
      if (a1 > best) begin
         idx  = 2'd1;
         best = a1;
      end
      if (a2 > best) begin
         idx  = 2'd2;
         best = a2;
      end
      if (a3 > best) begin
         idx  = 2'd3;
      end
   end

endmodule

// File: rtl/asic_readout_scheduler.sv
// Sequences settle / DRP read / average over four mux channels,
// then reports per-channel results and the strongest channel.
module asic_readout_scheduler
   import asic_bridge_pkg::*;
#(
   parameter int         DRDY_TIMEOUT = 255,
   parameter logic [6:0] VPVN_ADDR    = 7'h03
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             continuous,
   input  logic [15:0]      settle_cycles,
   input  logic [1:0]       avg_log2,
   output logic [6:0]       DADDR,
   output logic             DEN,
   output logic             DWE,
   output logic [15:0]      DI,
   input  logic             DRDY,
   input  logic [15:0]      DO,
   output logic [1:0]       mux_addr,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic [ADC_W-1:0] MEASURED_AUX0,
   output logic [ADC_W-1:0] MEASURED_AUX1,
   output logic [ADC_W-1:0] MEASURED_AUX2,
   output logic [ADC_W-1:0] MEASURED_AUX3,
   output logic [1:0]       network_output
);

   localparam int WT_W = $clog2(DRDY_TIMEOUT + 1);

   state_t            state, state_nx;
   logic [1:0]        ch;
   logic [15:0]       settle_q;
   logic [1:0]        avg_q;
   logic [15:0]       settle_cnt;
   logic [WT_W-1:0]   wait_cnt;
   logic [ACC_W-1:0]  acc;
   logic [3:0]        nsamp;
   logic [ADC_W-1:0]  aux [NUM_CH];
   logic [1:0]        best_idx;
   logic              go;
   logic              settle_done;
   logic              sample_last;
   logic              wait_expired;

   assign go           = start | continuous;
   assign settle_done  = (settle_q == 16'd0) ||
                         (settle_cnt == settle_q - 16'd1);
   assign sample_last  = (nsamp + 4'd1) == (4'd1 << avg_q);
   assign wait_expired = wait_cnt == WT_W'(DRDY_TIMEOUT - 1);

   channel_argmax u_argmax (
      .a0  (aux[0]),
      .a1  (aux[1]),
      .a2  (aux[2]),
      .a3  (aux[3]),
      .idx (best_idx)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:      if (go) state_nx = SETTLE;
         SETTLE:    if (settle_done) state_nx = READ_REQ;
         READ_REQ:  state_nx = READ_WAIT;
         READ_WAIT: begin
            if (DRDY)
               state_nx = sample_last ? STORE : READ_REQ;
            else if (wait_expired)
               state_nx = IDLE;
         end
         STORE:     state_nx = (ch == 2'd3) ? COMPARE : SETTLE;
         COMPARE:   state_nx = continuous ? SETTLE : IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      DEN   = (state == READ_REQ);
      DADDR = DEN ? VPVN_ADDR : 7'd0;
      DWE   = 1'b0;
      DI    = 16'd0;
      busy  = (state != IDLE);
      done  = (state == COMPARE);
   end

   // Sweep datapath: channel, counters, accumulator, results
   always_ff @(posedge clk) begin
      if (rst) begin
         ch             <= 2'd0;
         mux_addr       <= 2'd0;
         settle_q       <= 16'd0;
         avg_q          <= 2'd0;
         settle_cnt     <= 16'd0;
         wait_cnt       <= '0;
         acc            <= '0;
         nsamp          <= 4'd0;
         timeout_err    <= 1'b0;
         network_output <= 2'd0;
         for (int i = 0; i < NUM_CH; i++) aux[i] <= '0;
      end else begin
         settle_cnt <= (state == SETTLE) ? settle_cnt + 16'd1 : 16'd0;
         unique case (state)
            IDLE: begin
               if (go) begin
                  ch          <= 2'd0;
                  mux_addr    <= 2'd0;
                  timeout_err <= 1'b0;
                  settle_q    <= settle_cycles;
                  avg_q       <= avg_log2;
               end
            end
            SETTLE: begin
               acc   <= '0;
               nsamp <= 4'd0;
            end
            READ_REQ: wait_cnt <= '0;
            READ_WAIT: begin
               if (DRDY) begin
                  acc   <= acc + ACC_W'(DO >> 4);
                  nsamp <= nsamp + 4'd1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                  if (wait_expired) timeout_err <= 1'b1;
               end
            end
            STORE: begin
               aux[ch] <= ADC_W'(acc >> avg_q);
               if (ch != 2'd3) begin
                  ch       <= ch + 2'd1;
                  mux_addr <= ch + 2'd1;
               end
            end
            COMPARE: begin
               network_output <= best_idx;
               if (continuous) begin
                  ch       <= 2'd0;
                  mux_addr <= 2'd0;
                  settle_q <= settle_cycles;
                  avg_q    <= avg_log2;
               end
            end
            default: ;
         endcase
      end
   end

   assign MEASURED_AUX0 = aux[0];
   assign MEASURED_AUX1 = aux[1];
   assign MEASURED_AUX2 = aux[2];
   assign MEASURED_AUX3 = aux[3];

endmodule
